// File: rtl/div_iter_64_by_32.sv
`default_nettype none
// ============================================================================
// Module   : div_iter_64_by_32
// Purpose  : Iterative radix-2 restoring divider. It divides a 2*WIDTH-bit
//            unsigned dividend by a WIDTH-bit unsigned divisor and returns a
//            WIDTH-bit quotient and remainder. It reports divide-by-zero and
//            quotient overflow, has valid/ready handshakes on both sides and
//            keeps one division in flight at a time.
// Revision : 1.0 - initial release
// ============================================================================
module div_iter_64_by_32 #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,        // asynchronous, active-low
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Partial remainder, quotient/dividend shift register, latched divisor
  // and iteration counter.
  logic [WIDTH-1:0] rem_acc;
  logic [WIDTH-1:0] quo_acc;
  logic [WIDTH-1:0] div_reg;
  logic [CNT_W-1:0] count;

  // Per-iteration combinational datapath
  logic             is_zero;
  logic             is_ovf;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             last_iter;

  // Exception detection on the incoming operands. The quotient fits in
  // WIDTH bits only when the upper dividend half is below the divisor.
  always_comb begin
    is_zero = (divisor == '0);
    is_ovf  = (dividend[2*WIDTH-1:WIDTH] >= divisor);
  end

  // One restoring step: shift {R,Q} left, trial-subtract the divisor.
  // The partial remainder is always below the divisor, so it is stored in
  // WIDTH bits; the shifted value needs WIDTH+1 bits and is never truncated
  // before the subtraction. Within that range the MSB of the WIDTH+1-bit
  // difference is exactly the borrow flag.
  always_comb begin
    shifted   = {rem_acc, quo_acc[WIDTH-1]};
    diff      = shifted - {1'b0, div_reg};
    fits      = ~diff[WIDTH];
    rem_step  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_step  = {quo_acc[WIDTH-2:0], fits};
    last_iter = (count == CNT_W'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = (is_zero || is_ovf) ? DONE : CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, iteration and result registers. Results are
  // written only on the final CALC step or the exception accept, so they
  // stay stable for the whole DONE period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_acc     <= '0;
      quo_acc     <= '0;
      div_reg     <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_zero) begin
              quotient    <= '1;
              remainder   <= dividend[WIDTH-1:0];
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (is_ovf) begin
              quotient    <= '1;
              remainder   <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
            end else begin
              rem_acc     <= dividend[2*WIDTH-1:WIDTH];
              quo_acc     <= dividend[WIDTH-1:0];
              div_reg     <= divisor;
              count       <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
            end
          end
        end
        CALC: begin
          rem_acc <= rem_step;
          quo_acc <= quo_step;
          count   <= count + CNT_W'(1);
          if (last_iter) begin
            quotient  <= quo_step;
            remainder <= rem_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_iter_64_by_32.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_iter_64_by_32
// Purpose  : Self-checking bench for div_iter_64_by_32: directed vector
//            table, handshake/reset sequences and randomized division checks
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_iter_64_by_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  div_iter_64_by_32 #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] dd;
    logic [31:0] dv;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    logic        o;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the documented rules.
  task automatic model(input logic [63:0] dd, input logic [31:0] dv,
                       output logic [31:0] q, output logic [31:0] r,
                       output logic z, output logic o, output int lat);
    logic [63:0] full_q;
    logic [63:0] full_r;
    z = 1'b0;
    o = 1'b0;
    if (dv == 32'd0) begin
      q = 32'hFFFF_FFFF; r = dd[31:0]; z = 1'b1; lat = 1;
    end else begin
      full_q = dd / {32'd0, dv};
      full_r = dd % {32'd0, dv};
      if (full_q > 64'h0000_0000_FFFF_FFFF) begin
        q = 32'hFFFF_FFFF; r = 32'd0; o = 1'b1; lat = 1;
      end else begin
        q = full_q[31:0]; r = full_r[31:0]; lat = 33;
      end
    end
  endtask

  // Issue one division starting #1 after an edge with out_ready=1; returns
  // the result and latency (clocks from accept edge until out_valid seen),
  // then completes the output handshake.
  task automatic run_div(input logic [63:0] dd, input logic [31:0] dv,
                         output logic [31:0] q, output logic [31:0] r,
                         output logic z, output logic o, output int lat);
    int w;
    dividend = dd;
    divisor  = dv;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 200) begin
      @(posedge clk); #1; w++;
    end
    if (!in_ready) check("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) check("out_valid_timeout", 64'd0, 64'd1);
    q = quotient;
    r = remainder;
    z = div_by_zero;
    o = overflow;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] q, r, mq, mr, a, b;
    logic        z, o, mz, mo;
    int          lat, mlat, w;
    logic [63:0] dd;
    logic [31:0] dv;

    vecs[0]  = '{64'd75,                  32'd3,           32'd25,          32'd0,          1'b0, 1'b0, 33};
    vecs[1]  = '{64'd6230497307,          32'd78922,       32'd78945,       32'd17,         1'b0, 1'b0, 33};
    vecs[2]  = '{64'd0,                   32'd7,           32'd0,           32'd0,          1'b0, 1'b0, 33};
    vecs[3]  = '{64'd65,                  32'd0,           32'hFFFF_FFFF,   32'd65,         1'b1, 1'b0, 1};
    vecs[4]  = '{64'h0000_0005_0000_0000, 32'd5,           32'hFFFF_FFFF,   32'd0,          1'b0, 1'b1, 1};
    vecs[5]  = '{64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF,   32'hFFFF_FFFF,   32'hFFFF_FFFE,  1'b0, 1'b0, 33};
    vecs[6]  = '{64'h0000_0006_FFFF_FFFF, 32'd7,           32'hFFFF_FFFF,   32'd6,          1'b0, 1'b0, 33};
    vecs[7]  = '{64'h0000_0007_0000_0000, 32'd7,           32'hFFFF_FFFF,   32'd0,          1'b0, 1'b1, 1};
    vecs[8]  = '{64'h0000_0000_DEAD_BEEF, 32'd1,           32'hDEAD_BEEF,   32'd0,          1'b0, 1'b0, 33};
    vecs[9]  = '{64'h1234_5678_9ABC_DEF0, 32'd0,           32'hFFFF_FFFF,   32'h9ABC_DEF0,  1'b1, 1'b0, 1};
    vecs[10] = '{64'd100,                 32'd7,           32'd14,          32'd2,          1'b0, 1'b0, 33};
    vecs[11] = '{64'd3,                   32'd5,           32'd0,           32'd3,          1'b0, 1'b0, 33};

    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),    64'd1);
    check("rst_out_valid", 64'(out_valid),   64'd0);
    check("rst_quotient",  64'(quotient),    64'd0);
    check("rst_remainder", 64'(remainder),   64'd0);
    check("rst_dbz",       64'(div_by_zero), 64'd0);
    check("rst_ovf",       64'(overflow),    64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run_div(vecs[i].dd, vecs[i].dv, q, r, z, o, lat);
      check($sformatf("vec%0d_q", i),   64'(q),   64'(vecs[i].q));
      check($sformatf("vec%0d_r", i),   64'(r),   64'(vecs[i].r));
      check($sformatf("vec%0d_dbz", i), 64'(z),   64'(vecs[i].z));
      check($sformatf("vec%0d_ovf", i), 64'(o),   64'(vecs[i].o));
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Back-pressure in DONE; a second request held during CALC/DONE must wait
    out_ready = 1'b0;
    dividend  = 64'd100;
    divisor   = 32'd7;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    dividend  = 64'd200;
    divisor   = 32'd9;
    w = 0;
    while (!out_valid && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_q", 64'(quotient), 64'd14);
    check("bp_r", 64'(remainder), 64'd2);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d_valid", k), 64'(out_valid), 64'd1);
      check($sformatf("bp_hold%0d_ready", k), 64'(in_ready),  64'd0);
      check($sformatf("bp_hold%0d_q", k),     64'(quotient),  64'd14);
      check($sformatf("bp_hold%0d_r", k),     64'(remainder), 64'd2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_ready", 64'(in_ready),  64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 1;
    while (!out_valid && w < 100) begin
      @(posedge clk); #1; w++;
    end
    check("bp_second_lat", 64'(w), 64'd33);
    check("bp_second_q", 64'(quotient), 64'd22);
    check("bp_second_r", 64'(remainder), 64'd2);
    @(posedge clk); #1;

    // Reset in the middle of an iteration
    dividend = 64'd1000;
    divisor  = 32'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready",  64'(in_ready),  64'd1);
    check("midrst_quotient",  64'(quotient),  64'd0);
    check("midrst_remainder", 64'(remainder), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    run_div(64'd75, 32'd3, q, r, z, o, lat);
    check("recover_q",   64'(q),   64'd25);
    check("recover_r",   64'(r),   64'd0);
    check("recover_lat", 64'(lat), 64'd33);

    // Random products a*b divided by b must give back a exactly
    for (int i = 0; i < 1000; i++) begin
      a = $urandom();
      b = $urandom();
      if (a == 32'd0) a = 32'd1;
      if (b == 32'd0) b = 32'd1;
      dd = {32'd0, a} * {32'd0, b};
      run_div(dd, b, q, r, z, o, lat);
      if (q !== a || r !== 32'd0 || z !== 1'b0 || o !== 1'b0 || lat != 33)
        $display("FAIL prod%0d: a=%0h b=%0h got q=%0h r=%0h z=%0b o=%0b lat=%0d", i, a, b, q, r, z, o, lat);
      check($sformatf("prod%0d_q", i), 64'(q), 64'(a));
      check($sformatf("prod%0d_r", i), 64'(r), 64'd0);
      check($sformatf("prod%0d_flags", i), 64'({z, o}), 64'd0);
      check($sformatf("prod%0d_lat", i), 64'(lat), 64'd33);
    end

    // Fully random operands, including zero divisors and overflows
    for (int i = 0; i < 200; i++) begin
      dd = {$urandom(), $urandom()};
      dv = $urandom();
      case ($urandom_range(0, 3))
        0: dv = 32'd0;
        1: ;
        default: if (dv != 32'd0) dd[63:32] = dd[63:32] % dv;
      endcase
      model(dd, dv, mq, mr, mz, mo, mlat);
      run_div(dd, dv, q, r, z, o, lat);
      check($sformatf("rnd%0d_q", i),   64'(q),   64'(mq));
      check($sformatf("rnd%0d_r", i),   64'(r),   64'(mr));
      check($sformatf("rnd%0d_dbz", i), 64'(z),   64'(mz));
      check($sformatf("rnd%0d_ovf", i), 64'(o),   64'(mo));
      check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(mlat));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
